// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection controller with a latched pedestrian walk phase and a
// level-sensitive all-red emergency override. Lamps decode from the state register.
module traffic_intersection_ctrl #(
  parameter int GREEN_CYCLES   = 8,
  parameter int YELLOW_CYCLES  = 3,
  parameter int ALL_RED_CYCLES = 2,
  parameter int PED_CYCLES     = 6,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_req,
  input  logic       emergency,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_G    = 3'd0,
    NS_Y    = 3'd1,
    ALL_RED = 3'd2,
    EW_G    = 3'd3,
    EW_Y    = 3'd4,
    WALK    = 3'd5,
    EMERG   = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(ALL_RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] PED_LAST    = CNT_W'(PED_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             next_dir;  // 1: EW gets the next green, 0: NS
  logic             done;

  // An out-of-range state counts as done so it falls into recovery at once.
  always_comb begin
    done = 1'b1;
    case (state)
      NS_G, EW_G: done = (cnt == GREEN_LAST);
      NS_Y, EW_Y: done = (cnt == YELLOW_LAST);
      ALL_RED:    done = (cnt == RED_LAST);
      WALK:       done = (cnt == PED_LAST);
      EMERG:      done = 1'b0;
      default:    done = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= NS_G;
      cnt         <= '0;
      next_dir    <= 1'b1;
      ped_pending <= 1'b0;
    end else begin
      if (ped_req && state != WALK) ped_pending <= 1'b1;
      if (emergency) begin
        state <= EMERG;
        cnt   <= '0;
      end else if (state == EMERG) begin
        state    <= ALL_RED;
        cnt      <= '0;
        next_dir <= 1'b0;
      end else if (done) begin
        cnt <= '0;
        case (state)
          NS_G: state <= NS_Y;
          NS_Y: begin
            state    <= ALL_RED;
            next_dir <= 1'b1;
          end
          EW_G: state <= EW_Y;
          EW_Y: begin
            state    <= ALL_RED;
            next_dir <= 1'b0;
          end
          ALL_RED: begin
            // Clearing here overrides a same-edge ped_req: it is absorbed by this walk.
            if (ped_pending) begin
              state       <= WALK;
              ped_pending <= 1'b0;
            end else begin
              state <= next_dir ? EW_G : NS_G;
            end
          end
          WALK:    state <= next_dir ? EW_G : NS_G;
          default: state <= ALL_RED;
        endcase
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    ns_red    = 1'b1;
    ns_yellow = 1'b0;
    ns_green  = 1'b0;
    ew_red    = 1'b1;
    ew_yellow = 1'b0;
    ew_green  = 1'b0;
    case (state)
      NS_G: begin ns_red = 1'b0; ns_green  = 1'b1; end
      NS_Y: begin ns_red = 1'b0; ns_yellow = 1'b1; end
      EW_G: begin ew_red = 1'b0; ew_green  = 1'b1; end
      EW_Y: begin ew_red = 1'b0; ew_yellow = 1'b1; end
      default: ;
    endcase
  end

  assign walk  = (state == WALK);
  assign phase = state;

endmodule

// File: doc/traffic_intersection_ctrl.md
Name: traffic_intersection_ctrl

Overview:
- Parametrised successor to the single-signal traffic_signal block.
- Drives a two-road intersection, north-south (NS) and east-west (EW), with per-phase durations set by parameters.
- Adds a latched pedestrian walk phase and a level-sensitive emergency all-red override.
- Moore machine; all lamp outputs are decoded from the registered state. Sits under the same board-level top as traffic_signal.

Parameters:
- GREEN_CYCLES, 8, clock cycles each green phase lasts (>=1)
- YELLOW_CYCLES, 3, clock cycles each yellow phase lasts (>=1)
- ALL_RED_CYCLES, 2, clock cycles of the all-red clearance phase (>=1)
- PED_CYCLES, 6, clock cycles of the pedestrian walk phase (>=1)
- CNT_W, 8, phase-counter width; every duration must be <= 2^CNT_W

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-high reset
- ped_req  input  1  pedestrian button; any cycle high sets the pending latch
- emergency  input  1  level request for the all-red override
- ns_red / ns_yellow / ns_green  output  1 each  NS lamps, exactly one high
- ew_red / ew_yellow / ew_green  output  1 each  EW lamps, exactly one high
- walk  output  1  pedestrian walk lamp
- ped_pending  output  1  latched pedestrian request
- phase  output  3  current state: 0 NS_G, 1 NS_Y, 2 ALL_RED, 3 EW_G, 4 EW_Y, 5 WALK, 6 EMERG

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset state: phase=NS_G, cnt=0, next_dir=EW, ped_pending=0.
  - Outputs during and after reset: ns_green=1, ew_red=1, all other lamps 0, walk=0.
- Cycle numbering: cycle 0 is the first clock period with reset low.
- Phase counter: cnt increments each cycle. A phase of duration D occupies exactly D cycles; on the edge ending its last cycle (cnt==D-1), the state advances and cnt clears to 0.
- Transitions on phase done:
  - NS_G -> NS_Y
  - NS_Y -> ALL_RED, next_dir<=EW
  - EW_G -> EW_Y
  - EW_Y -> ALL_RED, next_dir<=NS
  - ALL_RED -> WALK if ped_pending, else the green selected by next_dir
  - WALK -> the green selected by next_dir
- Lamp decode:
  - NS_G: ns_green, ew_red
  - NS_Y: ns_yellow, ew_red
  - EW_G: ew_green, ns_red
  - EW_Y: ew_yellow, ns_red
  - ALL_RED / WALK / EMERG: both reds
  - walk=1 only in WALK
- Pedestrian latch:
  - Set on any edge where ped_req=1, except while in WALK.
  - Cleared on the edge entering WALK. A ped_req sampled on that same edge is absorbed, not re-latched.
  - Requests during WALK are ignored.
  - A pending request is served only at the next ALL_RED. It never shortens a green.
- Emergency:
  - Preemption is immediate from any non-EMERG state, including mid-yellow and mid-WALK: the edge sampling emergency=1 moves the state to EMERG and clears cnt.
  - Remains in EMERG while emergency=1. No duration limit applies.
  - The edge sampling emergency=0 in EMERG moves to ALL_RED with next_dir<=NS, so the road resumes with a full clearance and then a fresh full NS green.
  - ped_pending is kept across EMERG (a latch set during EMERG is still honoured).
- Priority per edge: reset > emergency > phase-done transition > cnt increment.
- Invariants:
  - Never green or yellow on both roads at once.
  - A green is always preceded by an ALL_RED, or is the reset state.
  - walk=1 implies both roads red.
  - phase values 7 and above are unreachable; if one is ever entered, recover to ALL_RED on the next edge.

Test Plan:
- Default parameters, no requests -> NS_G cycles 0-7, NS_Y 8-10, ALL_RED 11-12, EW_G 13-20, EW_Y 21-23, ALL_RED 24-25, NS_G again at 26 (26-cycle period). Lamp one-hot checked every cycle.
- ped_req one-cycle pulse in cycle 3 -> ped_pending=1 from cycle 4, ALL_RED 11-12, WALK (walk=1) 13-18, ped_pending=0 from cycle 13, EW_G 19-26.
- emergency high cycles 5-9 -> NS_G 0-5, EMERG (all red, walk=0) 6-10, ALL_RED 11-12, NS_G 13-20 full length.
- ped_req held high across a whole WALK, then dropped on WALK's last cycle -> no second WALK at the next ALL_RED. Repeat with ped_req pulsed during EMERG -> WALK is served after the post-emergency ALL_RED.
- reset asserted for one cycle mid EW_G with ped_pending=1 -> next cycle phase=NS_G, ns_green=1, ped_pending=0, and the 8-cycle NS green restarts from count 0.
- Override parameters GREEN=1, YELLOW=1, ALL_RED=1, PED=1 -> every phase lasts exactly one cycle: period 6 without walk, 7 with walk. Invariants hold.
